ifft_4point: RTL and testbench

//   Streaming 4-point inverse FFT: one frame = 4 complex frequency bins F0..F3 in, 4 time samples x0..x3 out.

---
 rtl/ifft4_pkg.sv | 38 +++
 rtl/ifft_4point_if.sv | 26 ++
 rtl/ifft_bfly2.sv | 27 ++
 rtl/ifft_4point.sv | 105 ++++++++++
 tb/tb_ifft_4point.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ifft4_pkg.sv
// ifft4_pkg: widths, complex types and the 1/4 scaling helper.
// Define IFFT4_ROUND_EN for round-half-up scaling instead of floor.
package ifft4_pkg;

  localparam int DW   = 32;
  localparam int S1_W = DW + 1;
  localparam int S2_W = DW + 2;

  typedef struct packed {
    logic signed [DW-1:0] re;
    logic signed [DW-1:0] im;
  } cplx_t;

  typedef struct packed {
    logic signed [S1_W-1:0] re;
    logic signed [S1_W-1:0] im;
  } cplx_s1_t;

  typedef struct packed {
    logic signed [S2_W-1:0] re;
    logic signed [S2_W-1:0] im;
  } cplx_s2_t;

  // 34b stage-2 value to 16.16; the sum of four DW values always fits.
  function automatic logic signed [DW-1:0] scale_q2(
    input logic signed [S2_W-1:0] v
  );
    logic signed [S2_W-1:0] t;
`ifdef IFFT4_ROUND_EN
    t = v + S2_W'(2);
`else
    t = v;
`endif
    t = t >>> 2;
    return t[DW-1:0];
  endfunction

endpackage

// File: rtl/ifft_4point_if.sv
// ifft_4point_if: frame-in / samples-out valid/ready bus.
// master = frame source and sample sink, slave = the transform.
interface ifft_4point_if #(
  parameter int CNT_W = 16
);
  import ifft4_pkg::*;

  logic             in_valid;
  logic             in_ready;
  cplx_t [3:0]      f;
  logic             out_valid;
  logic             out_ready;
  cplx_t [3:0]      x;
  logic [CNT_W-1:0] frame_cnt;

  modport master (
    output in_valid, f, out_ready,
    input  in_ready, out_valid, x, frame_cnt
  );

  modport slave (
    input  in_valid, f, out_ready,
    output in_ready, out_valid, x, frame_cnt
  );

endinterface

// File: rtl/ifft_bfly2.sv
// ifft_bfly2: complex radix-2 butterfly, sum and difference.
// Outputs grow by one bit so the result never wraps.
module ifft_bfly2 #(
  parameter int W = 32
) (
  input  logic signed [W-1:0] a_re_i,
  input  logic signed [W-1:0] a_im_i,
  input  logic signed [W-1:0] b_re_i,
  input  logic signed [W-1:0] b_im_i,
  output logic signed [W:0]   s_re_o,
  output logic signed [W:0]   s_im_o,
  output logic signed [W:0]   d_re_o,
  output logic signed [W:0]   d_im_o
);

  function automatic logic signed [W:0] sx(
    input logic signed [W-1:0] v
  );
    return {v[W-1], v};
  endfunction

  assign s_re_o = sx(a_re_i) + sx(b_re_i);
  assign s_im_o = sx(a_im_i) + sx(b_im_i);
  assign d_re_o = sx(a_re_i) - sx(b_re_i);
  assign d_im_o = sx(a_im_i) - sx(b_im_i);

endmodule

// File: rtl/ifft_4point.sv
// ifft_4point: streaming 4-point inverse FFT, 3 register stages.
// Build option IFFT4_ROUND_EN selects rounding in the final 1/4 scale.
module ifft_4point
  import ifft4_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input logic         clk,
  input logic         rst_n,
  ifft_4point_if.slave bus
);

  logic             en;
  logic             v0_q, v1_q, v2_q;
  cplx_t [3:0]      f_q;
  cplx_s1_t         a0_q, a1_q, b0_q, b1_q;
  cplx_s1_t         a0_d, a1_d, b0_d, b1_d;
  cplx_s2_t         x0_w, x1_w, x2_w, x3_w;
  cplx_t [3:0]      x_q, x_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign en = bus.out_ready || !v2_q;

  ifft_bfly2 #(.W(DW)) u_s1_a (
    .a_re_i(f_q[0].re), .a_im_i(f_q[0].im),
    .b_re_i(f_q[2].re), .b_im_i(f_q[2].im),
    .s_re_o(a0_d.re),   .s_im_o(a0_d.im),
    .d_re_o(a1_d.re),   .d_im_o(a1_d.im)
  );

  ifft_bfly2 #(.W(DW)) u_s1_b (
    .a_re_i(f_q[1].re), .a_im_i(f_q[1].im),
    .b_re_i(f_q[3].re), .b_im_i(f_q[3].im),
    .s_re_o(b0_d.re),   .s_im_o(b0_d.im),
    .d_re_o(b1_d.re),   .d_im_o(b1_d.im)
  );

  ifft_bfly2 #(.W(S1_W)) u_s2_e (
    .a_re_i(a0_q.re), .a_im_i(a0_q.im),
    .b_re_i(b0_q.re), .b_im_i(b0_q.im),
    .s_re_o(x0_w.re), .s_im_o(x0_w.im),
    .d_re_o(x2_w.re), .d_im_o(x2_w.im)
  );

  // +j*b1 by swapping b1's components: x1 = a1 + j*b1, x3 = a1 - j*b1
  ifft_bfly2 #(.W(S1_W)) u_s2_o (
    .a_re_i(a1_q.re), .a_im_i(a1_q.im),
    .b_re_i(b1_q.im), .b_im_i(b1_q.re),
    .s_re_o(x3_w.re), .s_im_o(x1_w.im),
    .d_re_o(x1_w.re), .d_im_o(x3_w.im)
  );

  always_comb begin
    x_d = '0;
    x_d[0].re = scale_q2(x0_w.re);
    x_d[0].im = scale_q2(x0_w.im);
    x_d[1].re = scale_q2(x1_w.re);
    x_d[1].im = scale_q2(x1_w.im);
    x_d[2].re = scale_q2(x2_w.re);
    x_d[2].im = scale_q2(x2_w.im);
    x_d[3].re = scale_q2(x3_w.re);
    x_d[3].im = scale_q2(x3_w.im);
  end

  always_comb begin
    cnt_d = cnt_q;
    if (v2_q && bus.out_ready) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v0_q  <= 1'b0;
      v1_q  <= 1'b0;
      v2_q  <= 1'b0;
      f_q   <= '0;
      a0_q  <= '0;
      a1_q  <= '0;
      b0_q  <= '0;
      b1_q  <= '0;
      x_q   <= '0;
      cnt_q <= '0;
    end else begin
      if (en) begin
        v0_q <= bus.in_valid;
        v1_q <= v0_q;
        v2_q <= v1_q;
      end
      if (en && bus.in_valid) f_q <= bus.f;
      if (en && v0_q) begin
        a0_q <= a0_d;
        a1_q <= a1_d;
        b0_q <= b0_d;
        b1_q <= b1_d;
      end
      if (en && v1_q) x_q <= x_d;
      cnt_q <= cnt_d;
    end
  end

  assign bus.in_ready  = en;
  assign bus.out_valid = v2_q;
  assign bus.x         = x_q;
  assign bus.frame_cnt = cnt_q;

endmodule

// File: tb/tb_ifft_4point.sv
// tb_ifft_4point: scoreboard bench for ifft_4point.
// Expected samples come from a direct 4-point inverse DFT model.
module tb_ifft_4point;
  import ifft4_pkg::*;

  typedef cplx_t [3:0] frame_t;
  typedef struct {
    frame_t x;
    int     edge_n;
    bit     lat;
  } exp_t;

  logic   clk;
  logic   rst_n;
  int     n_cmp = 0;
  int     n_bad = 0;
  int     cyc = 0;
  int     n_del = 0;
  int     n_acc = 0;
  bit     rand_rdy = 0;
  bit     held = 0;
  frame_t held_x;
  exp_t   sb[$];
  exp_t   e;

  ifft_4point_if #(.CNT_W(16)) bus();

  ifft_4point #(.CNT_W(16)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic frame_t model(input frame_t f);
    longint r[4], i[4], vr[4], vi[4];
    frame_t x;
    for (int k = 0; k < 4; k++) begin
      r[k] = longint'($signed(f[k].re));
      i[k] = longint'($signed(f[k].im));
    end
    vr[0] = r[0] + r[1] + r[2] + r[3];
    vi[0] = i[0] + i[1] + i[2] + i[3];
    vr[1] = r[0] - i[1] - r[2] + i[3];
    vi[1] = i[0] + r[1] - i[2] - r[3];
    vr[2] = r[0] - r[1] + r[2] - r[3];
    vi[2] = i[0] - i[1] + i[2] - i[3];
    vr[3] = r[0] + i[1] - r[2] - i[3];
    vi[3] = i[0] - r[1] - i[2] + r[3];
    x = '0;
    for (int n = 0; n < 4; n++) begin
`ifdef IFFT4_ROUND_EN
      vr[n] = vr[n] + 2;
      vi[n] = vi[n] + 2;
`endif
      vr[n] = vr[n] >>> 2;
      vi[n] = vi[n] >>> 2;
      x[n].re = vr[n][31:0];
      x[n].im = vi[n][31:0];
    end
    return x;
  endfunction

  function automatic frame_t mk(input logic [31:0] r0, r1, r2, r3);
    frame_t f;
    f = '0;
    f[0].re = r0;
    f[1].re = r1;
    f[2].re = r2;
    f[3].re = r3;
    return f;
  endfunction

  task automatic send(input frame_t f, input bit lat);
    exp_t s;
    int   t;
    t = 0;
    @(negedge clk);
    bus.f = f;
    bus.in_valid = 1'b1;
    #1;
    while (!bus.in_ready && t < 200) begin
      @(negedge clk);
      #1;
      t++;
    end
    if (!bus.in_ready) begin
      chk("in_ready_tmo", 64'(bus.in_ready), 64'd1);
      bus.in_valid = 1'b0;
    end else begin
      s.x = model(f);
      s.edge_n = cyc + 1;
      s.lat = lat;
      sb.push_back(s);
      n_acc++;
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (sb.size() != 0) chk("drain", 64'(sb.size()), 64'd0);
    repeat (2) @(negedge clk);
  endtask

  always @(negedge clk)
    if (rand_rdy) bus.out_ready = ($urandom_range(0, 3) != 0);

  always @(negedge clk) begin
    #2;
    if (!rst_n) begin
      held = 1'b0;
    end else begin
      if (held) begin
        chk("hold_valid", 64'(bus.out_valid), 64'd1);
        for (int n = 0; n < 4; n++)
          chk("hold_x", 64'(bus.x[n]), 64'(held_x[n]));
      end
      held = bus.out_valid && !bus.out_ready;
      held_x = bus.x;
      if (bus.out_valid && bus.out_ready) begin
        n_del++;
        if (sb.size() == 0) begin
          chk("stale_frame", 64'(sb.size()), 64'd1);
        end else begin
          e = sb.pop_front();
          for (int n = 0; n < 4; n++)
            chk($sformatf("x%0d", n), 64'(bus.x[n]), 64'(e.x[n]));
          if (e.lat) chk("latency", 64'(cyc - e.edge_n), 64'd2);
        end
      end
    end
  end

  initial begin
    frame_t f;
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.f = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_frame_cnt", 64'(bus.frame_cnt), 64'd0);
    for (int n = 0; n < 4; n++) chk("rst_x", 64'(bus.x[n]), 64'd0);
    rst_n = 1'b1;
    #1 chk("rdy_after_rst", 64'(bus.in_ready), 64'd1);

    send(mk(32'h0004_0000, 0, 0, 0), 1'b1);
    send(mk(0, 32'h0004_0000, 0, 0), 1'b1);
    send(mk(32'h0000_0003, 0, 0, 0), 1'b1);
    send(mk(32'hFFFF_FFFD, 0, 0, 0), 1'b1);
    send(mk(32'h7FFF_FFFF, 32'h7FFF_FFFF,
            32'h7FFF_FFFF, 32'h7FFF_FFFF), 1'b1);
    send(mk(32'h8000_0000, 32'h8000_0000,
            32'h8000_0000, 32'h8000_0000), 1'b1);
    drain();

    rand_rdy = 1'b1;
    for (int k = 0; k < 20; k++) begin
      for (int n = 0; n < 4; n++) begin
        f[n].re = $urandom;
        f[n].im = $urandom;
      end
      send(f, 1'b0);
    end
    rand_rdy = 1'b0;
    @(negedge clk);
    bus.out_ready = 1'b1;
    drain();
    chk("frame_cnt", 64'(bus.frame_cnt), 64'(n_del));

    @(negedge clk) rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    n_acc = 0;
    bus.out_ready = 1'b0;
    fork
      begin
        for (int k = 0; k < 6; k++) begin
          f = mk($urandom, $urandom, $urandom, $urandom);
          f[1].im = $urandom;
          f[3].im = $urandom;
          send(f, 1'b0);
        end
      end
      begin
        repeat (5) @(negedge clk);
        chk("bp_accepts", 64'(n_acc), 64'd3);
        chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
        bus.out_ready = 1'b1;
      end
    join
    drain();
    chk("bp_frame_cnt", 64'(bus.frame_cnt), 64'd6);

    @(negedge clk) bus.out_ready = 1'b0;
    send(mk(32'h0001_0000, 32'h0002_0000, 0, 0), 1'b0);
    send(mk(32'h0003_0000, 0, 32'h0001_0000, 0), 1'b0);
    @(posedge clk);
    #1 chk("pre_rst_valid", 64'(bus.out_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(bus.out_valid), 64'd0);
    chk("mid_rst_cnt", 64'(bus.frame_cnt), 64'd0);
    for (int n = 0; n < 4; n++) chk("mid_rst_x", 64'(bus.x[n]), 64'd0);
    sb.delete();
    @(negedge clk) rst_n = 1'b1;
    #1 chk("rdy_after_rst2", 64'(bus.in_ready), 64'd1);
    bus.out_ready = 1'b1;
    send(mk(32'h0000_4000, 32'hFFFF_C000, 32'h0001_0000, 0), 1'b1);
    drain();
    chk("post_rst_cnt", 64'(bus.frame_cnt), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
